stream_delimiter: RTL

//  Registered AXI-Stream field splitter. Each accepted input beat is cut into NUM_OUTPUTS

---
 rtl/stream_delimiter_pkg.sv | 45 ++++
 rtl/stream_delimiter_lane.sv | 47 ++++
 rtl/stream_delimiter.sv | 116 +++++++++++
 3 files changed

// File: rtl/stream_delimiter_pkg.sv
// stream_delimiter_pkg
// Shared constants and helper functions for the stream_delimiter field splitter.
//   MAX_OUTPUTS   : largest number of output channels the splitter supports
//   EXT_MAX       : width of the scratch value used by extend(); lanes are cut from it
//   width_array_t : per-channel field widths, index n = field n
//   field_offset  : LSB position of field idx inside the input word
//   extend        : zero/sign extension of a field held in the low bits of a wide value
package stream_delimiter_pkg;

  localparam int MAX_OUTPUTS = 8;
  localparam int EXT_MAX     = 64;

  typedef int width_array_t [MAX_OUTPUTS];

  // Fields are packed LSB-first, so the offset of a field is the sum of the
  // widths of every field below it.
  function automatic int field_offset(input int idx, input width_array_t widths);
    int off;
    off = 0;
    for (int i = 0; i < MAX_OUTPUTS; i++) begin
      if (i < idx) off += widths[i];
    end
    return off;
  endfunction

  // Bits below 'width' are copied; every bit above is filled with the field's
  // top bit when 'sign' is set, otherwise with zero. A 1-bit signed field
  // therefore replicates across the whole result.
  function automatic logic [EXT_MAX-1:0] extend(input logic [EXT_MAX-1:0] field,
                                                input int width,
                                                input logic sign);
    logic [EXT_MAX-1:0] result;
    logic fill;
    fill = 1'b0;
    for (int i = 0; i < EXT_MAX; i++) begin
      if (i == width - 1) fill = sign & field[i];
    end
    result = '0;
    for (int i = 0; i < EXT_MAX; i++) begin
      result[i] = (i < width) ? field[i] : fill;
    end
    return result;
  endfunction

endpackage

// File: rtl/stream_delimiter_lane.sv
// stream_delimiter_lane
// One output channel of the splitter: a single-entry register holding data,
// last and valid for one AXI-Stream master port.
//   aclk, areset : clock and synchronous active-high reset
//   load         : input beat accepted this cycle, capture load_data/load_last
//   load_data    : already extended field for this lane
//   load_last    : copy of the input tlast
//   m_tready     : downstream ready for this lane
//   m_tdata/m_tlast/m_tvalid : registered lane outputs
//   can_accept   : lane is empty or draining this cycle, feeds the top-level AND
module stream_delimiter_lane #(
  parameter int WIDTH = 8
) (
  input  logic             aclk,
  input  logic             areset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tlast,
  output logic             m_tvalid,
  output logic             can_accept
);

  // The register may take a new beat when nothing is held or the held beat
  // leaves this very cycle, which keeps full throughput with ready held high.
  assign can_accept = !m_tvalid || m_tready;

  // Load wins over drain so a fire and an accept in the same cycle leave
  // valid set with the new beat. load is only ever raised when can_accept is
  // true, so held data never changes while it waits for m_tready.
  always_ff @(posedge aclk) begin
    if (areset) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
    end else if (load) begin
      m_tvalid <= 1'b1;
      m_tdata  <= load_data;
      m_tlast  <= load_last;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_delimiter.sv
// stream_delimiter
// Registered AXI-Stream field splitter: each accepted input beat is cut into
// NUM_OUTPUTS LSB-first fields, each extended to an OUT_MAX-wide lane and
// forked to its own output stream with independent valid/ready.
//   aclk, areset   : clock and synchronous active-high reset
//   s_axis_*       : input stream (tdata IN0_WIDTH wide, tvalid, tlast, tready)
//   m_axis_tdata   : lane n at bits [n*OUT_MAX +: OUT_MAX]
//   m_axis_tvalid/tlast/tready : one bit per channel
//   beat_count     : accepted input beats, wraps modulo 2^32
module stream_delimiter
  import stream_delimiter_pkg::*;
#(
  parameter int         IN0_WIDTH   = 32,
  parameter int         NUM_OUTPUTS = 4,
  parameter int         OUT0_WIDTH  = 8,
  parameter int         OUT1_WIDTH  = 8,
  parameter int         OUT2_WIDTH  = 8,
  parameter int         OUT3_WIDTH  = 8,
  parameter int         OUT4_WIDTH  = 8,
  parameter int         OUT5_WIDTH  = 8,
  parameter int         OUT6_WIDTH  = 8,
  parameter int         OUT7_WIDTH  = 8,
  parameter int         OUT_MAX     = 8,
  parameter logic [7:0] SIGN_EXT    = 8'h00
) (
  input  logic                           aclk,
  input  logic                           areset,
  input  logic [IN0_WIDTH-1:0]           s_axis_tdata,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic [NUM_OUTPUTS*OUT_MAX-1:0] m_axis_tdata,
  output logic [NUM_OUTPUTS-1:0]         m_axis_tvalid,
  output logic [NUM_OUTPUTS-1:0]         m_axis_tlast,
  input  logic [NUM_OUTPUTS-1:0]         m_axis_tready,
  output logic [31:0]                    beat_count
);

  localparam width_array_t WIDTHS = '{OUT0_WIDTH, OUT1_WIDTH, OUT2_WIDTH, OUT3_WIDTH,
                                      OUT4_WIDTH, OUT5_WIDTH, OUT6_WIDTH, OUT7_WIDTH};
  localparam int TOTAL_WIDTH = field_offset(NUM_OUTPUTS, WIDTHS);

  // Reject configurations that cannot be sliced.
  if (NUM_OUTPUTS < 1 || NUM_OUTPUTS > MAX_OUTPUTS) begin : g_bad_num
    $error("stream_delimiter: NUM_OUTPUTS must be in 1..8");
  end
  if (TOTAL_WIDTH > IN0_WIDTH) begin : g_bad_total
    $error("stream_delimiter: active field widths exceed IN0_WIDTH");
  end
  if (OUT_MAX < 1 || OUT_MAX > EXT_MAX) begin : g_bad_lane
    $error("stream_delimiter: OUT_MAX must be in 1..64");
  end

  // Input bits above the last field carry nothing for any lane.
  if (TOTAL_WIDTH < IN0_WIDTH) begin : g_drop_upper
    logic unused_upper;
    assign unused_upper = ^s_axis_tdata[IN0_WIDTH-1:TOTAL_WIDTH];
  end

  logic [NUM_OUTPUTS-1:0] can_accept;
  logic                   accept;

  // Ready is a pure function of the lane registers and downstream readies,
  // never of s_axis_tvalid, and is held low during reset.
  assign s_axis_tready = !areset && (&can_accept);
  assign accept        = s_axis_tvalid && s_axis_tready;

  for (genvar n = 0; n < NUM_OUTPUTS; n++) begin : g_lane
    localparam int OFF = field_offset(n, WIDTHS);
    localparam int FW  = WIDTHS[n];

    logic [EXT_MAX-1:0] ext_full;
    logic [OUT_MAX-1:0] field_ext;

    if (FW < 1 || FW > OUT_MAX) begin : g_bad_width
      $error("stream_delimiter: active field width must be in 1..OUT_MAX");
    end

    assign ext_full  = extend(EXT_MAX'(s_axis_tdata[OFF +: FW]), FW, SIGN_EXT[n]);
    assign field_ext = ext_full[OUT_MAX-1:0];

    if (OUT_MAX < EXT_MAX) begin : g_trim
      logic unused_ext;
      assign unused_ext = ^ext_full[EXT_MAX-1:OUT_MAX];
    end

    stream_delimiter_lane #(
      .WIDTH(OUT_MAX)
    ) u_lane (
      .aclk       (aclk),
      .areset     (areset),
      .load       (accept),
      .load_data  (field_ext),
      .load_last  (s_axis_tlast),
      .m_tready   (m_axis_tready[n]),
      .m_tdata    (m_axis_tdata[n*OUT_MAX +: OUT_MAX]),
      .m_tlast    (m_axis_tlast[n]),
      .m_tvalid   (m_axis_tvalid[n]),
      .can_accept (can_accept[n])
    );
  end

  logic [31:0] count_q;

  // Free-running accept counter; natural 32-bit wrap.
  always_ff @(posedge aclk) begin
    if (areset) begin
      count_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign beat_count = count_q;

endmodule
